quad_encoder_gen: RTL



---
 rtl/quad_gen_pkg.sv | 38 +++
 rtl/sat_accum.sv | 77 +++++++
 rtl/quad_encoder_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/quad_gen_pkg.sv
// Shared types for the quadrature generator: Gray-code phase encoding,
// generator FSM states and the cw/ccw phase successor functions.
package quad_gen_pkg;

    // Encodings chosen so that bit 1 is phase A and bit 0 is phase B.
    typedef enum logic [1:0] {
        PH00 = 2'b00,
        PH10 = 2'b10,
        PH11 = 2'b11,
        PH01 = 2'b01
    } phase_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } gen_state_t;

    function automatic phase_t next_cw(input phase_t ph);
        case (ph)
            PH00:    return PH10;
            PH10:    return PH11;
            PH11:    return PH01;
            PH01:    return PH00;
            default: return PH00;
        endcase
    endfunction

    function automatic phase_t next_ccw(input phase_t ph);
        case (ph)
            PH00:    return PH01;
            PH01:    return PH11;
            PH11:    return PH10;
            PH10:    return PH00;
            default: return PH00;
        endcase
    endfunction

endpackage

// File: rtl/sat_accum.sv
// Signed saturating accumulator for pending quarter-steps: +STEP on inc,
// -STEP on dec, one count toward zero on step_toward_zero, clamped to +/-(2^(W-1)-1).
module sat_accum #(
    parameter int PEND_W = 8,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic              step_toward_zero,
    output logic [PEND_W-1:0] value,
    output logic              sat,
    output logic              nz_next
);
    localparam int MAX_I = (2 ** (PEND_W - 1)) - 1;
    localparam logic signed [PEND_W:0] MAX_V  = MAX_I[PEND_W:0];
    localparam logic signed [PEND_W:0] MIN_V  = -MAX_V;
    localparam logic signed [PEND_W:0] STEP_V = STEP[PEND_W:0];
    localparam logic signed [PEND_W:0] ONE_V  = {{PEND_W{1'b0}}, 1'b1};
    localparam logic signed [PEND_W:0] ZERO_V = {(PEND_W + 1){1'b0}};

    logic signed [PEND_W-1:0] r_value;
    logic signed [PEND_W:0]   w_ext;
    logic signed [PEND_W:0]   w_delta;
    logic signed [PEND_W:0]   w_toward;
    logic signed [PEND_W:0]   w_sum;
    logic signed [PEND_W-1:0] w_next;

    // Request and emission contributions summed one bit wide, then clamped.
    always_comb begin
        w_ext    = {r_value[PEND_W-1], r_value};
        w_delta  = ZERO_V;
        w_toward = ZERO_V;
        if (inc && !dec) begin
            w_delta = STEP_V;
        end else if (dec && !inc) begin
            w_delta = -STEP_V;
        end else begin
            w_delta = ZERO_V;
        end
        if (step_toward_zero && (|r_value)) begin
            if (r_value[PEND_W-1]) begin
                w_toward = ONE_V;
            end else begin
                w_toward = -ONE_V;
            end
        end else begin
            w_toward = ZERO_V;
        end
        w_sum  = w_ext + w_delta + w_toward;
        sat    = 1'b0;
        w_next = w_sum[PEND_W-1:0];
        if (w_sum > MAX_V) begin
            w_next = MAX_V[PEND_W-1:0];
            sat    = 1'b1;
        end else if (w_sum < MIN_V) begin
            w_next = MIN_V[PEND_W-1:0];
            sat    = 1'b1;
        end else begin
            w_next = w_sum[PEND_W-1:0];
            sat    = 1'b0;
        end
        nz_next = |w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= {PEND_W{1'b0}};
        end else begin
            r_value <= w_next;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B transmitter: buffers cw/ccw step requests and replays them
// as Gray-code phase transitions separated by at least PHASE_CYCLES+1 clocks.
module quad_encoder_gen
    import quad_gen_pkg::*;
#(
    parameter int QSTEPS_PER_REQ = 4,
    parameter int PHASE_CYCLES   = 5000,
    parameter int PEND_W         = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              cw,
    input  logic              ccw,
    input  logic              clear_ovf,
    output logic              a,
    output logic              b,
    output logic              busy,
    output logic              overflow,
    output logic [PEND_W-1:0] pending
);
    localparam int TMR_W      = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int TMR_LOAD_I = PHASE_CYCLES - 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_LOAD_I[TMR_W-1:0];
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1'b1);

    gen_state_t        r_state;
    gen_state_t        w_state_nx;
    logic [TMR_W-1:0]  r_timer;
    logic [TMR_W-1:0]  w_timer_nx;
    phase_t            r_phase;
    phase_t            w_phase_nx;
    logic              r_busy;
    logic              r_ovf;
    logic              w_emit;
    logic              w_sat;
    logic              w_nz_next;
    logic [PEND_W-1:0] w_pend;

    sat_accum #(
        .PEND_W (PEND_W),
        .STEP   (QSTEPS_PER_REQ)
    ) u_accum (
        .clk              (CLOCK_50),
        .reset            (reset),
        .inc              (cw),
        .dec              (ccw),
        .step_toward_zero (w_emit),
        .value            (w_pend),
        .sat              (w_sat),
        .nz_next          (w_nz_next)
    );

    // Emission decision: direction follows the sign of pending at each IDLE visit.
    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_phase_nx = r_phase;
        w_emit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_pend) begin
                    w_emit     = 1'b1;
                    w_state_nx = DWELL;
                    w_timer_nx = TMR_LOAD;
                    if (w_pend[PEND_W-1]) begin
                        w_phase_nx = next_ccw(r_phase);
                    end else begin
                        w_phase_nx = next_cw(r_phase);
                    end
                end else begin
                    w_state_nx = IDLE;
                end
            end
            DWELL: begin
                if (r_timer == TMR_ZERO) begin
                    w_state_nx = IDLE;
                end else begin
                    w_timer_nx = r_timer - TMR_ONE;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_timer_nx = TMR_ZERO;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= TMR_ZERO;
            r_phase <= PH00;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_phase <= w_phase_nx;
            r_busy  <= (w_state_nx == DWELL) || w_nz_next;
            // A saturating request outranks a simultaneous clear.
            if (w_sat) begin
                r_ovf <= 1'b1;
            end else if (clear_ovf) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    assign a        = r_phase[1];
    assign b        = r_phase[0];
    assign busy     = r_busy;
    assign overflow = r_ovf;
    assign pending  = w_pend;

endmodule
